mem_port_arbiter: RTL and testbench

// - Shares one synchronous single-port memory between instruction fetch (IF) and the execute-stage load/store port (LS).
// - Sits between fetch, the execute stage's ldst_addr/ldst_write/ldst_data signals, and the memory macro.
// - LS has fixed priority. A skip counter bounds IF starvation.
// - Allows one outstanding read at a time. Denied requesters see gnt low and stall their stage.

---
 rtl/mem_port_arbiter_pkg.sv | 30 +++
 rtl/mem_port_arbiter_arb_pick.sv | 22 ++
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared parameters and types for the instruction-fetch / load-store memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int ADDR   = 16;
  localparam int W_OPR  = 32;
  localparam int SKIP_W = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_e;

  typedef struct packed {
    arb_state_e        state;
    arb_owner_e        owner;
    logic [1:0]        lat_cnt;
    logic [SKIP_W-1:0] skip_cnt;
  } arb_dbg_t;

  function automatic logic [SKIP_W-1:0] sat_inc(input logic [SKIP_W-1:0] v,
                                                input logic [SKIP_W-1:0] max_v);
    return (v >= max_v) ? max_v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Winner select between fetch and load/store; the saturated skip count hands IF one forced win.
module arb_pick (
  input  logic if_req,
  input  logic ls_req,
  input  logic skip_sat,
  output logic grant_if,
  output logic grant_ls
);

  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (skip_sat && if_req) begin
      grant_if = 1'b1;
    end else if (ls_req) begin
      grant_ls = 1'b1;
    end else if (if_req) begin
      grant_if = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch and load/store with a single outstanding read.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT  = 1,
  parameter int MAX_SKIP = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req_i,
  input  logic [ADDR-1:0]  if_addr_i,
  output logic             if_gnt_o,
  output logic             if_rvalid_o,
  output logic [W_OPR-1:0] if_rdata_o,
  input  logic             ls_req_i,
  input  logic             ls_write_i,
  input  logic [ADDR-1:0]  ls_addr_i,
  input  logic [W_OPR-1:0] ls_wdata_i,
  output logic             ls_gnt_o,
  output logic             ls_rvalid_o,
  output logic [W_OPR-1:0] ls_rdata_o,
  output logic             mem_en_o,
  output logic             mem_we_o,
  output logic [ADDR-1:0]  mem_addr_o,
  output logic [W_OPR-1:0] mem_wdata_o,
  input  logic [W_OPR-1:0] mem_rdata_i,
  output arb_dbg_t         dbg_o
);

  localparam logic [1:0]        LAT_LOAD = 2'(MEM_LAT - 1);
  localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(MAX_SKIP);

  arb_state_e        state_r;
  arb_owner_e        owner_r;
  logic [1:0]        lat_cnt_r;
  logic [SKIP_W-1:0] skip_cnt_r;

  logic ret_now;
  logic slot;
  logic pick_if;
  logic pick_ls;
  logic if_gnt;
  logic ls_gnt;
  logic read_gnt;

  arb_pick u_pick (
    .if_req   (if_req_i),
    .ls_req   (ls_req_i),
    .skip_sat (skip_cnt_r == SKIP_MAX),
    .grant_if (pick_if),
    .grant_ls (pick_ls)
  );

  // Handshake: a request is accepted in the cycle its gnt is high; until then the
  // requester holds req/addr/data stable. Read data follows with rvalid MEM_LAT cycles later.
  always_comb begin
    ret_now  = (state_r == ARB_WAIT) && (lat_cnt_r == 2'd0);
    slot     = reset && ((state_r == ARB_IDLE) || ret_now);
    if_gnt   = slot && pick_if;
    ls_gnt   = slot && pick_ls;
    read_gnt = if_gnt || (ls_gnt && !ls_write_i);
  end

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (ls_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = ls_write_i;
      mem_addr_o  = ls_addr_i;
      mem_wdata_o = ls_wdata_i;
    end else if (if_gnt) begin
      mem_en_o   = 1'b1;
      mem_addr_o = if_addr_i;
    end
  end

  always_comb begin
    if_gnt_o    = if_gnt;
    ls_gnt_o    = ls_gnt;
    if_rvalid_o = ret_now && (owner_r == OWN_IF);
    ls_rvalid_o = ret_now && (owner_r == OWN_LS);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : '0;
    dbg_o       = '{state: state_r, owner: owner_r, lat_cnt: lat_cnt_r, skip_cnt: skip_cnt_r};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ARB_IDLE;
      owner_r    <= OWN_IF;
      lat_cnt_r  <= '0;
      skip_cnt_r <= '0;
    end else begin
      // A read granted in the return cycle re-arms WAIT for back-to-back reads.
      if (read_gnt) begin
        state_r   <= ARB_WAIT;
        owner_r   <= if_gnt ? OWN_IF : OWN_LS;
        lat_cnt_r <= LAT_LOAD;
      end else if (state_r == ARB_WAIT) begin
        if (lat_cnt_r == 2'd0) begin
          state_r <= ARB_IDLE;
        end else begin
          lat_cnt_r <= lat_cnt_r - 1'b1;
        end
      end

      if (!if_req_i || if_gnt) begin
        skip_cnt_r <= '0;
      end else if (ls_gnt) begin
        skip_cnt_r <= sat_inc(skip_cnt_r, SKIP_MAX);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT 1 and 2) share stimulus, each checked against its own model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MAX_SKIP = 3;
  localparam int N_INST   = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             if_req;
  logic [ADDR-1:0]  if_addr;
  logic             ls_req;
  logic             ls_write;
  logic [ADDR-1:0]  ls_addr;
  logic [W_OPR-1:0] ls_wdata;
  logic [W_OPR-1:0] mem_rdata;

  logic             if_gnt    [N_INST];
  logic             if_rvalid [N_INST];
  logic [W_OPR-1:0] if_rdata  [N_INST];
  logic             ls_gnt    [N_INST];
  logic             ls_rvalid [N_INST];
  logic [W_OPR-1:0] ls_rdata  [N_INST];
  logic             mem_en    [N_INST];
  logic             mem_we    [N_INST];
  logic [ADDR-1:0]  mem_addr  [N_INST];
  logic [W_OPR-1:0] mem_wdata [N_INST];
  arb_dbg_t         dbg       [N_INST];

  // clock / reset
  always #5 clk = ~clk;

  for (genvar g = 0; g < N_INST; g++) begin : g_dut
    mem_port_arbiter #(.MEM_LAT(g + 1), .MAX_SKIP(MAX_SKIP)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .if_req_i    (if_req),
      .if_addr_i   (if_addr),
      .if_gnt_o    (if_gnt[g]),
      .if_rvalid_o (if_rvalid[g]),
      .if_rdata_o  (if_rdata[g]),
      .ls_req_i    (ls_req),
      .ls_write_i  (ls_write),
      .ls_addr_i   (ls_addr),
      .ls_wdata_i  (ls_wdata),
      .ls_gnt_o    (ls_gnt[g]),
      .ls_rvalid_o (ls_rvalid[g]),
      .ls_rdata_o  (ls_rdata[g]),
      .mem_en_o    (mem_en[g]),
      .mem_we_o    (mem_we[g]),
      .mem_addr_o  (mem_addr[g]),
      .mem_wdata_o (mem_wdata[g]),
      .mem_rdata_i (mem_rdata),
      .dbg_o       (dbg[g])
    );
  end

  // reference model: outstanding read as (return cycle, owner), plus IF denial count
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   ret_cycle [N_INST];
  logic ret_is_ls [N_INST];
  int   skip      [N_INST];
  logic [W_OPR-1:0] exp_q [$];

  task automatic chk(input string tag, input int inst, input logic [W_OPR-1:0] obs,
                     input logic [W_OPR-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[lat%0d] cyc=%0d observed=0x%0h expected=0x%0h", tag, inst + 1, cyc, obs, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [ADDR-1:0] ia, input logic lr,
                       input logic lw, input logic [ADDR-1:0] la, input logic [W_OPR-1:0] ld);
    if_req   = ir;
    if_addr  = ia;
    ls_req   = lr;
    ls_write = lw;
    ls_addr  = la;
    ls_wdata = ld;
  endtask

  // One cycle: inputs already driven at the falling edge; check mid-low-phase, then advance.
  task automatic step();
    logic returning, can_grant, win_if, win_ls, exp_rv_if, exp_rv_ls;
    mem_rdata = $urandom();
    #1;
    for (int i = 0; i < N_INST; i++) begin
      if (!reset) begin
        ret_cycle[i] = -1;
        skip[i]      = 0;
      end
      returning = (ret_cycle[i] == cyc);
      can_grant = reset && (ret_cycle[i] < 0 || returning);
      win_if = 1'b0;
      win_ls = 1'b0;
      if (can_grant) begin
        if (skip[i] == MAX_SKIP && if_req) win_if = 1'b1;
        else if (ls_req)                   win_ls = 1'b1;
        else if (if_req)                   win_if = 1'b1;
      end
      exp_rv_if = returning && !ret_is_ls[i];
      exp_rv_ls = returning && ret_is_ls[i];

      exp_q.delete();
      exp_q.push_back(exp_rv_if ? mem_rdata : '0);
      exp_q.push_back(exp_rv_ls ? mem_rdata : '0);

      chk("if_gnt", i, W_OPR'(if_gnt[i]), W_OPR'(win_if));
      chk("ls_gnt", i, W_OPR'(ls_gnt[i]), W_OPR'(win_ls));
      chk("mem_en", i, W_OPR'(mem_en[i]), W_OPR'(win_if || win_ls));
      chk("mem_we", i, W_OPR'(mem_we[i]), W_OPR'(win_ls && ls_write));
      if (win_if) chk("mem_addr", i, W_OPR'(mem_addr[i]), W_OPR'(if_addr));
      if (win_ls) chk("mem_addr", i, W_OPR'(mem_addr[i]), W_OPR'(ls_addr));
      if (win_ls && ls_write) chk("mem_wdata", i, mem_wdata[i], ls_wdata);
      chk("if_rvalid", i, W_OPR'(if_rvalid[i]), W_OPR'(exp_rv_if));
      chk("ls_rvalid", i, W_OPR'(ls_rvalid[i]), W_OPR'(exp_rv_ls));
      chk("if_rdata", i, if_rdata[i], exp_q.pop_front());
      chk("ls_rdata", i, ls_rdata[i], exp_q.pop_front());
      chk("skip_cnt", i, W_OPR'(dbg[i].skip_cnt), W_OPR'(skip[i]));

      if (reset) begin
        if (returning) ret_cycle[i] = -1;
        if (win_if || (win_ls && !ls_write)) begin
          ret_cycle[i] = cyc + i + 1;
          ret_is_ls[i] = win_ls;
        end
        if (!if_req || win_if) skip[i] = 0;
        else if (win_ls && skip[i] < MAX_SKIP) skip[i] = skip[i] + 1;
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    for (int i = 0; i < N_INST; i++) begin
      ret_cycle[i] = -1;
      ret_is_ls[i] = 1'b0;
      skip[i]      = 0;
    end
    reset     = 1'b0;
    mem_rdata = '0;
    drive(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0020, '0);
    @(negedge clk);

    // reset held with both requests high
    for (int k = 0; k < 3; k++) step();

    // release: LS wins the first slot, IF follows once a slot opens
    reset = 1'b1;
    for (int k = 0; k < 2; k++) step();
    drive(1'b1, 16'h0010, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 3; k++) step();
    idle(3);

    // single IF read at 0x0040
    drive(1'b1, 16'h0040, 1'b0, 1'b0, '0, '0);
    step();
    idle(3);

    // store to 0x0100 with a pending IF read, then the IF read
    drive(1'b1, 16'h0040, 1'b1, 1'b1, 16'h0100, 32'hDEADBEEF);
    step();
    drive(1'b1, 16'h0040, 1'b0, 1'b0, '0, '0);
    step();
    idle(3);

    // starvation: both held high, LS issuing loads
    drive(1'b1, 16'h0200, 1'b1, 1'b0, 16'h0300, '0);
    for (int k = 0; k < 20; k++) step();
    idle(3);

    // back-to-back reads, alternating requesters
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) drive(1'b1, 16'(16'h0400 + k), 1'b0, 1'b0, '0, '0);
      else            drive(1'b0, '0, 1'b1, 1'b0, 16'(16'h0500 + k), '0);
      step();
    end
    idle(3);

    // reset during WAIT: lat=2 instance has one cycle of latency left
    drive(1'b0, '0, 1'b1, 1'b0, 16'h0600, '0);
    step();
    idle(0);
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    idle(2);
    drive(1'b1, 16'h0700, 1'b0, 1'b0, '0, '0);
    step();
    idle(3);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom()), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0), 16'($urandom()), $urandom());
      reset = ($urandom_range(0, 59) != 0);
      step();
    end
    reset = 1'b1;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
